tdm_demux8: RTL and testbench



---
 rtl/tdm_demux8.sv | 87 ++++++++
 tb/tb_tdm_demux8.sv | 138 +++++++++++++
 2 files changed

// File: rtl/tdm_demux8.sv
// tdm_demux8: 8-slot TDM deserialiser with frame-sync alignment, flywheel and sync-fault reporting
// clk/rst_n: clock, async active-low reset; en: slot enable; din: serial data; fsync: slot-0 marker
// y: last complete frame (y[k] = slot k); valid: y update strobe; slot: next expected slot
// locked: in RUN; sync_err: early or missing sync pulse
module tdm_demux8 #(
  parameter int SYNC_LOSS = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       din,
  input  logic       fsync,
  output logic [7:0] y,
  output logic       valid,
  output logic [2:0] slot,
  output logic       locked,
  output logic       sync_err
);
  typedef enum logic {HUNT, RUN} state_t;
  localparam logic [2:0] LOSS = 3'(SYNC_LOSS);
  state_t st, st_n;
  logic [7:0] sh, sh_n, y_n;
  logic [2:0] cnt, cnt_n, miss, miss_n;
  logic valid_n, err_n;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st <= HUNT;
      sh <= '0;
      cnt <= '0;
      miss <= '0;
      y <= '0;
      valid <= 1'b0;
      sync_err <= 1'b0;
    end else begin
      st <= st_n;
      sh <= sh_n;
      cnt <= cnt_n;
      miss <= miss_n;
      y <= y_n;
      valid <= valid_n;
      sync_err <= err_n;
    end
  always_comb begin
    st_n = st;
    sh_n = sh;
    cnt_n = cnt;
    miss_n = miss;
    y_n = y;
    valid_n = 1'b0;
    err_n = 1'b0;
    if (en) begin
      if (st == HUNT) begin
        if (fsync) begin
          st_n = RUN;
          sh_n = {7'b0, din};
          cnt_n = 3'd1;
          miss_n = '0;
        end
      end else if (fsync && cnt != 3'd0) begin
        err_n = 1'b1;
        sh_n = {7'b0, din};
        cnt_n = 3'd1;
        miss_n = '0;
      end else if (!fsync && cnt == 3'd0) begin
        err_n = 1'b1;
        if (miss + 3'd1 == LOSS) begin
          st_n = HUNT;
          miss_n = '0;
        end else begin
          miss_n = miss + 3'd1;
          sh_n = {7'b0, din};
          cnt_n = 3'd1;
        end
      end else begin
        sh_n[cnt] = din;
        cnt_n = cnt + 3'd1;
        miss_n = cnt == 3'd0 ? 3'd0 : miss;
        if (cnt == 3'd7) begin
          y_n = {din, sh[6:0]};
          valid_n = 1'b1;
        end
      end
    end
  end
  assign slot = cnt;
  assign locked = st == RUN;
endmodule

// File: tb/tb_tdm_demux8.sv
// tb_tdm_demux8: scoreboard bench for tdm_demux8
module tb_tdm_demux8;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, din = 1'b0, fsync = 1'b0;
  logic [7:0] y;
  logic valid, locked, sync_err;
  logic [2:0] slot;
  int checks = 0, errors = 0, vcount = 0, ecount = 0;
  logic [7:0] q[$];
  tdm_demux8 #(.SYNC_LOSS(2)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .din(din), .fsync(fsync),
    .y(y), .valid(valid), .slot(slot), .locked(locked), .sync_err(sync_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic step(input logic e, input logic f, input logic d);
    @(negedge clk);
    en = e;
    fsync = f;
    din = d;
    @(posedge clk);
    #1;
    if (valid) begin
      vcount++;
      if (q.size() == 0) chk("valid_spurious", {7'b0, valid}, 8'h00);
      else chk("y", y, q.pop_front());
    end
    if (sync_err) ecount++;
  endtask
  task automatic send_frame(input logic [7:0] d, input logic fs, input logic push);
    if (push) q.push_back(d);
    for (int k = 0; k < 8; k++) begin
      step(1'b1, fs && k == 0, d[k]);
      chk("slot", {5'b0, slot}, 8'((k + 1) % 8));
      chk("locked", {7'b0, locked}, 8'h01);
      chk("valid", {7'b0, valid}, {7'b0, push && k == 7});
      chk("sync_err", {7'b0, sync_err}, {7'b0, k == 0 && !fs});
    end
  endtask
  initial begin
    logic [7:0] d;
    int v0, e0;
    #2;
    chk("rst_y", y, 8'h00);
    chk("rst_valid", {7'b0, valid}, 8'h00);
    chk("rst_slot", {5'b0, slot}, 8'h00);
    chk("rst_locked", {7'b0, locked}, 8'h00);
    chk("rst_err", {7'b0, sync_err}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    v0 = vcount;
    send_frame(8'h55, 1'b1, 1'b1);
    chk("t1_vcount", 8'(vcount - v0), 8'd1);
    v0 = vcount;
    e0 = ecount;
    for (int n = 0; n < 8; n++) send_frame(8'h01 << n, 1'b1, 1'b1);
    chk("t2_vcount", 8'(vcount - v0), 8'd8);
    chk("t2_errs", 8'(ecount - e0), 8'd0);
    d = 8'h55;
    q.push_back(d);
    for (int k = 0; k < 4; k++) step(1'b1, k == 0, d[k]);
    for (int g = 0; g < 3; g++) begin
      step(1'b0, 1'(g), 1'(~g));
      chk("gap_slot", {5'b0, slot}, 8'd4);
      chk("gap_valid", {7'b0, valid}, 8'h00);
      chk("gap_err", {7'b0, sync_err}, 8'h00);
    end
    for (int k = 4; k < 8; k++) step(1'b1, 1'b0, d[k]);
    chk("t3_y", y, 8'h55);
    chk("t3_slot", {5'b0, slot}, 8'h00);
    d = 8'h3C;
    for (int k = 0; k < 5; k++) step(1'b1, k == 0, d[k]);
    d = 8'hC3;
    q.push_back(d);
    step(1'b1, 1'b1, d[0]);
    chk("es_err", {7'b0, sync_err}, 8'h01);
    chk("es_valid", {7'b0, valid}, 8'h00);
    chk("es_slot", {5'b0, slot}, 8'h01);
    chk("es_y", y, 8'h55);
    for (int k = 1; k < 8; k++) begin
      step(1'b1, 1'b0, d[k]);
      chk("es_valid_seq", {7'b0, valid}, {7'b0, k == 7});
      if (k < 7) chk("es_y_hold", y, 8'h55);
    end
    d = 8'hF0;
    for (int k = 0; k < 7; k++) step(1'b1, k == 0, d[k]);
    d = 8'h0F;
    q.push_back(d);
    step(1'b1, 1'b1, d[0]);
    chk("es7_err", {7'b0, sync_err}, 8'h01);
    chk("es7_valid", {7'b0, valid}, 8'h00);
    chk("es7_y", y, 8'hC3);
    for (int k = 1; k < 8; k++) step(1'b1, 1'b0, d[k]);
    chk("es7_ynew", y, 8'h0F);
    send_frame(8'h96, 1'b1, 1'b1);
    send_frame(8'h69, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    chk("loss_err", {7'b0, sync_err}, 8'h01);
    chk("loss_locked", {7'b0, locked}, 8'h00);
    chk("loss_slot", {5'b0, slot}, 8'h00);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b0, 1'b1);
      chk("hunt_locked", {7'b0, locked}, 8'h00);
      chk("hunt_slot", {5'b0, slot}, 8'h00);
      chk("hunt_err", {7'b0, sync_err}, 8'h00);
    end
    chk("hunt_y", y, 8'h69);
    send_frame(8'hA5, 1'b1, 1'b1);
    chk("relock_y", y, 8'hA5);
    d = 8'h77;
    for (int k = 0; k < 4; k++) step(1'b1, k == 0, d[k]);
    chk("pre_rst_slot", {5'b0, slot}, 8'd4);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_y", y, 8'h00);
    chk("arst_valid", {7'b0, valid}, 8'h00);
    chk("arst_locked", {7'b0, locked}, 8'h00);
    chk("arst_slot", {5'b0, slot}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 1'b0, 1'b1);
      chk("post_locked", {7'b0, locked}, 8'h00);
      chk("post_slot", {5'b0, slot}, 8'h00);
      chk("post_valid", {7'b0, valid}, 8'h00);
    end
    send_frame(8'h3A, 1'b1, 1'b1);
    chk("final_y", y, 8'h3A);
    chk("sb_empty", 8'(q.size()), 8'h00);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
